mdu_hilo_ctrl: RTL and testbench

Multiply/divide sequencer and HI/LO register owner for the EXE stage. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the ID_EXE pipeline register. Runs a multi-cycle multiply or a 32-iteration restoring divide. Stalls the front of the pipeline while busy, aborts cleanly on flush, and commits results to HI/LO exactly once per instruction.

---
 rtl/mdu_hilo_ctrl.sv | 176 +++++++++++++++++
 tb/tb_mdu_hilo_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mdu_hilo_ctrl.sv
// Multiply/divide sequencer for the EXE stage; owns the architectural HI/LO pair.
// Stalls the pipeline front while busy and commits one HI/LO result per instruction.
//
// state | meaning
// IDLE  | accept MULT/MULTU/DIV/DIVU, or write HI/LO for MTHI/MTLO
// MUL   | MUL_CYCLES multiply cycles, product registered each cycle
// DIV   | 32 restoring steps on {remainder, quotient}
// FIX   | sign correction of quotient and remainder
// DONE  | commit result to HI/LO (unless flushed)
module mdu_hilo_ctrl #(
    parameter int MUL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  EXE_MDUOp,
    input  logic [31:0] EXE_BusA,
    input  logic [31:0] EXE_BusB,
    input  logic        EXE_Flush,
    output logic        EXE_MDUStall,
    output logic        MDU_Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [5:0] MUL_LAST = 6'(MUL_CYCLES - 1);
    localparam logic [5:0] DIV_LAST = 6'd31;

    state_t      state;
    logic [5:0]  cnt;
    logic        signed_op;
    logic        sign_a;
    logic        sign_b;
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic [31:0] divisor;
    logic [63:0] rq;
    logic [63:0] result;

    logic        is_mul;
    logic        is_div;
    logic        div_signed;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic signed [32:0] mul_a;
    logic signed [32:0] mul_b;
    logic signed [65:0] prod_full;
    logic [32:0] rem_sh;
    logic [33:0] diff;
    logic [63:0] rq_next;
    logic [31:0] rem_fix;
    logic [31:0] quo_fix;

    always_comb begin
        is_mul     = (EXE_MDUOp == OP_MULT) || (EXE_MDUOp == OP_MULTU);
        is_div     = (EXE_MDUOp == OP_DIV) || (EXE_MDUOp == OP_DIVU);
        div_signed = (EXE_MDUOp == OP_DIV);
        mag_a      = (div_signed && EXE_BusA[31]) ? (~EXE_BusA + 32'd1) : EXE_BusA;
        mag_b      = (div_signed && EXE_BusB[31]) ? (~EXE_BusB + 32'd1) : EXE_BusB;

        // Sign-extend to 33 bits for MULT, zero-extend for MULTU.
        mul_a     = {signed_op & a_reg[31], a_reg};
        mul_b     = {signed_op & b_reg[31], b_reg};
        prod_full = mul_a * mul_b;

        // Restoring step; the shifted remainder can need 33 bits.
        rem_sh = rq[63:31];
        diff   = {1'b0, rem_sh} - {2'b00, divisor};
        if (!diff[33])
            rq_next = {diff[31:0], rq[30:0], 1'b1};
        else
            rq_next = {rem_sh[31:0], rq[30:0], 1'b0};

        rem_fix = sign_a ? (~rq[63:32] + 32'd1) : rq[63:32];
        quo_fix = (sign_a ^ sign_b) ? (~rq[31:0] + 32'd1) : rq[31:0];

        EXE_MDUStall = !EXE_Flush &&
                       (((state == S_IDLE) && (is_mul || is_div)) ||
                        (state == S_MUL) || (state == S_DIV) || (state == S_FIX));
        MDU_Busy = (state != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= 6'd0;
            signed_op <= 1'b0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            a_reg     <= 32'd0;
            b_reg     <= 32'd0;
            divisor   <= 32'd0;
            rq        <= 64'd0;
            result    <= 64'd0;
            HI        <= 32'd0;
            LO        <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!EXE_Flush) begin
                        if (is_mul) begin
                            a_reg     <= EXE_BusA;
                            b_reg     <= EXE_BusB;
                            signed_op <= (EXE_MDUOp == OP_MULT);
                            cnt       <= 6'd0;
                            state     <= S_MUL;
                        end else if (is_div) begin
                            signed_op <= div_signed;
                            sign_a    <= div_signed & EXE_BusA[31];
                            sign_b    <= div_signed & EXE_BusB[31];
                            rq        <= {32'd0, mag_a};
                            divisor   <= mag_b;
                            cnt       <= 6'd0;
                            state     <= S_DIV;
                        end else if (EXE_MDUOp == OP_MTHI) begin
                            HI <= EXE_BusA;
                        end else if (EXE_MDUOp == OP_MTLO) begin
                            LO <= EXE_BusA;
                        end
                    end
                end
                S_MUL: begin
                    if (EXE_Flush) begin
                        state <= S_IDLE;
                    end else begin
                        result <= prod_full[63:0];
                        cnt    <= cnt + 6'd1;
                        if (cnt == MUL_LAST)
                            state <= S_DONE;
                    end
                end
                S_DIV: begin
                    if (EXE_Flush) begin
                        state <= S_IDLE;
                    end else begin
                        rq  <= rq_next;
                        cnt <= cnt + 6'd1;
                        if (cnt == DIV_LAST)
                            state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (EXE_Flush) begin
                        state <= S_IDLE;
                    end else begin
                        result <= {rem_fix, quo_fix};
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!EXE_Flush) begin
                        HI <= result[63:32];
                        LO <= result[31:0];
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_hilo_ctrl.sv
// Directed bench for mdu_hilo_ctrl: timing of stall, HI/LO results, flush and reset behaviour.
module tb_mdu_hilo_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  EXE_MDUOp;
    logic [31:0] EXE_BusA;
    logic [31:0] EXE_BusB;
    logic        EXE_Flush;
    logic        EXE_MDUStall;
    logic        MDU_Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks = 0;
    int failures = 0;
    int n;

    mdu_hilo_ctrl #(.MUL_CYCLES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .EXE_MDUOp    (EXE_MDUOp),
        .EXE_BusA     (EXE_BusA),
        .EXE_BusB     (EXE_BusB),
        .EXE_Flush    (EXE_Flush),
        .EXE_MDUStall (EXE_MDUStall),
        .MDU_Busy     (MDU_Busy),
        .HI           (HI),
        .LO           (LO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue an op, count stall-high cycles, drop the op in DONE, step past DONE.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cycles);
        EXE_MDUOp = op;
        EXE_BusA  = a;
        EXE_BusB  = b;
        #1;
        cycles = 0;
        while (EXE_MDUStall && cycles < 200) begin
            cycles++;
            tick();
        end
        chk("done_busy", {31'd0, MDU_Busy}, 32'd1);
        EXE_MDUOp = 3'd0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b0;
        EXE_MDUOp = 3'd0;
        EXE_BusA  = 32'd0;
        EXE_BusB  = 32'd0;
        EXE_Flush = 1'b0;
        #1;
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        chk("rst_stall", {31'd0, EXE_MDUStall}, 32'd0);
        chk("rst_busy", {31'd0, MDU_Busy}, 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        run_op(3'd1, 32'hFFFF_FFFE, 32'h0000_0003, n);
        chk("mult_stall", n, 32'd3);
        chk("mult_hi", HI, 32'hFFFF_FFFF);
        chk("mult_lo", LO, 32'hFFFF_FFFA);

        run_op(3'd2, 32'hFFFF_FFFE, 32'h0000_0003, n);
        chk("multu_stall", n, 32'd3);
        chk("multu_hi", HI, 32'h0000_0002);
        chk("multu_lo", LO, 32'hFFFF_FFFA);

        run_op(3'd3, 32'hFFFF_FFF9, 32'h0000_0002, n);
        chk("div_stall", n, 32'd34);
        chk("div_lo", LO, 32'hFFFF_FFFD);
        chk("div_hi", HI, 32'hFFFF_FFFF);

        run_op(3'd4, 32'd100, 32'd0, n);
        chk("divu0_lo", LO, 32'hFFFF_FFFF);
        chk("divu0_hi", HI, 32'd100);

        run_op(3'd3, 32'hFFFF_FFFB, 32'd0, n);
        chk("div0_lo", LO, 32'h0000_0001);
        chk("div0_hi", HI, 32'hFFFF_FFFB);

        run_op(3'd4, 32'd1000, 32'd7, n);
        chk("divu_lo", LO, 32'd142);
        chk("divu_hi", HI, 32'd6);

        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, n);
        chk("divovf_lo", LO, 32'h8000_0000);
        chk("divovf_hi", HI, 32'h0000_0000);

        // Flush partway through a divide.
        EXE_MDUOp = 3'd3;
        EXE_BusA  = 32'd9;
        EXE_BusB  = 32'd2;
        #1;
        chk("fdiv_issue_stall", {31'd0, EXE_MDUStall}, 32'd1);
        repeat (6) tick();
        chk("fdiv_mid_stall", {31'd0, EXE_MDUStall}, 32'd1);
        EXE_Flush = 1'b1;
        #1;
        chk("fdiv_flush_stall", {31'd0, EXE_MDUStall}, 32'd0);
        tick();
        EXE_Flush = 1'b0;
        EXE_MDUOp = 3'd0;
        #1;
        chk("fdiv_busy", {31'd0, MDU_Busy}, 32'd0);
        chk("fdiv_hi", HI, 32'h0000_0000);
        chk("fdiv_lo", LO, 32'h8000_0000);

        // Flush in DONE.
        EXE_MDUOp = 3'd2;
        EXE_BusA  = 32'd5;
        EXE_BusB  = 32'd7;
        repeat (3) tick();
        chk("fdone_busy", {31'd0, MDU_Busy}, 32'd1);
        chk("fdone_stall", {31'd0, EXE_MDUStall}, 32'd0);
        EXE_MDUOp = 3'd0;
        EXE_Flush = 1'b1;
        tick();
        EXE_Flush = 1'b0;
        #1;
        chk("fdone_idle", {31'd0, MDU_Busy}, 32'd0);
        chk("fdone_hi", HI, 32'h0000_0000);
        chk("fdone_lo", LO, 32'h8000_0000);

        // Flushed MTHI is dropped, then MTHI/MTLO back-to-back.
        EXE_MDUOp = 3'd5;
        EXE_BusA  = 32'hDEAD_BEEF;
        EXE_Flush = 1'b1;
        tick();
        EXE_Flush = 1'b0;
        chk("mthi_flush_hi", HI, 32'h0000_0000);
        EXE_BusA = 32'h0000_1234;
        #1;
        chk("mthi_stall", {31'd0, EXE_MDUStall}, 32'd0);
        tick();
        EXE_MDUOp = 3'd6;
        EXE_BusA  = 32'h0000_5678;
        tick();
        EXE_MDUOp = 3'd0;
        chk("mtlo_busy", {31'd0, MDU_Busy}, 32'd0);
        chk("mt_hi", HI, 32'h0000_1234);
        chk("mt_lo", LO, 32'h0000_5678);

        run_op(3'd2, 32'd3, 32'd4, n);
        chk("b2b_stall", n, 32'd3);
        chk("b2b_hi", HI, 32'd0);
        chk("b2b_lo", LO, 32'd12);

        // Reset mid-divide, checked without a clock edge.
        EXE_MDUOp = 3'd3;
        EXE_BusA  = 32'd1000;
        EXE_BusB  = 32'd3;
        repeat (11) tick();
        chk("rdiv_busy_pre", {31'd0, MDU_Busy}, 32'd1);
        #2;
        EXE_MDUOp = 3'd0;
        rst = 1'b0;
        #1;
        chk("rdiv_hi", HI, 32'd0);
        chk("rdiv_lo", LO, 32'd0);
        chk("rdiv_busy", {31'd0, MDU_Busy}, 32'd0);
        chk("rdiv_stall", {31'd0, EXE_MDUStall}, 32'd0);
        tick();
        rst = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
